sram_req_arbiter: RTL and testbench

//  Shares one SRAM-like memory port (req/addr_ok/data_ok) between the IF-stage instruction requester and the EXE/MEM data requester.

---
 rtl/sram_req_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Shares one SRAM-like memory port (req/addr_ok/data_ok) between the IF-stage
//   instruction requester and the EXE/MEM data requester. Data requests win over
//   instruction requests. A request the slave leaves pending stays locked until it
//   is accepted. Accepted transactions are tracked in an in-order ID FIFO, so each
//   data_ok/rdata is routed back to the requester that issued it.
//
// Ports
//   clk, resetn                 clock (rising edge), asynchronous active-low reset
//   inst_req/size/addr          IF read request
//   inst_addr_ok                IF request accepted this cycle
//   inst_data_ok/rdata          IF read data return
//   data_req/wr/size/wstrb/
//     addr/wdata                data load/store request
//   data_addr_ok                data request accepted this cycle
//   data_data_ok/rdata          load data / store acknowledge
//   mem_req/wr/size/wstrb/
//     addr/wdata                muxed request to the memory bridge
//   mem_addr_ok                 memory accepted mem_req this cycle
//   mem_data_ok/rdata           response for the oldest outstanding transaction
//   proto_err                   sticky: response seen with nothing outstanding
module sram_req_arbiter #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        resetn,
   // instruction side
   input  logic        inst_req,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   // data side
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // memory side
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic        proto_err
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      IdInst = 1'b0,
      IdData = 1'b1
   } req_id_e;

   // lock holds the grant of a request the slave has not yet accepted
   logic                lock_vld_q, lock_vld_d;
   req_id_e             lock_id_q, lock_id_d;
   // in-order ID FIFO, one bit per entry
   logic [DEPTH-1:0]    id_q, id_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                proto_err_q, proto_err_d;

   logic                grant_vld;
   req_id_e             grant_id;
   req_id_e             head_id;
   logic                fifo_full;
   logic                fifo_empty;
   logic                accept;
   logic                pop;

   assign fifo_full  = (count_q == CNT_W'(DEPTH));
   assign fifo_empty = (count_q == '0);
   assign head_id    = req_id_e'(id_q[rd_ptr_q]);

   // Grant: a locked request keeps the port even if data_req rises later.
   // Qualifying with resetn forces every request-side output low during reset.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = IdInst;
      if (lock_vld_q) begin
         grant_vld = resetn;
         grant_id  = lock_id_q;
      end else if (data_req) begin
         grant_vld = resetn;
         grant_id  = IdData;
      end else if (inst_req) begin
         grant_vld = resetn;
         grant_id  = IdInst;
      end
   end

   // Request mux, zero-cycle pass-through of the granted requester
   always_comb begin
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_size  = 2'd0;
      mem_wstrb = 4'd0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      if (grant_vld) begin
         if (grant_id == IdData) begin
            mem_req   = data_req & ~fifo_full;
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
         end else begin
            mem_req   = inst_req & ~fifo_full;
            mem_size  = inst_size;
            mem_addr  = inst_addr;
         end
      end
   end

   assign accept       = mem_req & mem_addr_ok;
   assign inst_addr_ok = accept & (grant_id == IdInst);
   assign data_addr_ok = accept & (grant_id == IdData);

   // Responses belong to the FIFO head; an empty FIFO means a protocol error
   assign pop          = mem_data_ok & ~fifo_empty;
   assign inst_data_ok = pop & (head_id == IdInst);
   assign data_data_ok = pop & (head_id == IdData);
   assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
   assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;
   assign proto_err    = proto_err_q;

   always_comb begin
      lock_vld_d  = lock_vld_q;
      lock_id_d   = lock_id_q;
      id_d        = id_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      proto_err_d = proto_err_q | (mem_data_ok & fifo_empty);

      if (accept) begin
         lock_vld_d = 1'b0;
      end else if (mem_req) begin
         lock_vld_d = 1'b1;
         lock_id_d  = grant_id;
      end

      if (accept) begin
         id_d[wr_ptr_q] = grant_id;
         wr_ptr_d       = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_vld_q  <= 1'b0;
         lock_id_q   <= IdInst;
         id_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         lock_vld_q  <= lock_vld_d;
         lock_id_q   <= lock_id_d;
         id_q        <= id_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         proto_err_q <= proto_err_d;
      end
   end

endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;

   logic        clk;
   logic        resetn;
   logic        inst_req;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;
   logic        proto_err;

   int checks;
   int errors;

   // {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, proto_err}
   logic [5:0] flags;
   assign flags = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, proto_err};

   sram_req_arbiter #(.DEPTH(2), .CNT_W(2)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_size    (inst_size),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .mem_wstrb    (mem_wstrb),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok),
      .mem_rdata    (mem_rdata),
      .proto_err    (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic idle_inputs();
      inst_req    = 1'b0;
      inst_size   = 2'd0;
      inst_addr   = 32'd0;
      data_req    = 1'b0;
      data_wr     = 1'b0;
      data_size   = 2'd0;
      data_wstrb  = 4'd0;
      data_addr   = 32'd0;
      data_wdata  = 32'd0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = 32'd0;
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle_inputs();
      #2;
      checks++;
      if (flags !== 6'b000000) begin
         errors++;
         $display("FAIL reset_flags: got %b want %b", flags, 6'b000000);
      end
      next_cycle();
      next_cycle();
      resetn = 1'b1;
      #1;
      checks++;
      if (flags !== 6'b000000 || mem_addr !== 32'd0) begin
         errors++;
         $display("FAIL reset_release: flags %b addr %h want 000000 / 0", flags, mem_addr);
      end
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         #1;
         checks++;
         if (flags !== 6'b000000) begin
            errors++;
            $display("FAIL idle_cycle_%0d: got %b want %b", i, flags, 6'b000000);
         end
      end
   endtask

   task automatic test_priority();
      next_cycle();
      inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0000_0100;
      data_req = 1'b1; data_size = 2'd2; data_addr = 32'h0000_0200;
      mem_addr_ok = 1'b1;
      #1;
      checks++;
      if (flags !== 6'b101000 || mem_addr !== 32'h200) begin
         errors++;
         $display("FAIL prio_data_first: flags %b addr %h want 101000 / 200", flags, mem_addr);
      end
      next_cycle();
      data_req = 1'b0;
      #1;
      checks++;
      if (flags !== 6'b110000 || mem_addr !== 32'h100 || mem_wr !== 1'b0) begin
         errors++;
         $display("FAIL prio_inst_second: flags %b addr %h wr %b want 110000 / 100 / 0",
                  flags, mem_addr, mem_wr);
      end
      next_cycle();
      inst_req = 1'b0; mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
      #1;
      checks++;
      if (flags !== 6'b000010 || data_rdata !== 32'h1111_1111 || inst_rdata !== 32'd0) begin
         errors++;
         $display("FAIL prio_resp_data: flags %b drd %h ird %h want 000010 / 11111111 / 0",
                  flags, data_rdata, inst_rdata);
      end
      next_cycle();
      mem_rdata = 32'h2222_2222;
      #1;
      checks++;
      if (flags !== 6'b000100 || inst_rdata !== 32'h2222_2222 || data_rdata !== 32'd0) begin
         errors++;
         $display("FAIL prio_resp_inst: flags %b ird %h drd %h want 000100 / 22222222 / 0",
                  flags, inst_rdata, data_rdata);
      end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_lock();
      inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0000_0300;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin
            data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hf;
            data_addr = 32'h0000_0400; data_wdata = 32'hdead_beef;
         end
         #1;
         checks++;
         if (flags !== 6'b100000 || mem_addr !== 32'h300 || mem_wr !== 1'b0
             || mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL lock_hold_%0d: flags %b addr %h wr %b strb %h want 100000/300/0/0",
                     c, flags, mem_addr, mem_wr, mem_wstrb);
         end
         next_cycle();
      end
      mem_addr_ok = 1'b1;
      #1;
      checks++;
      if (flags !== 6'b110000 || mem_addr !== 32'h300) begin
         errors++;
         $display("FAIL lock_accept_inst: flags %b addr %h want 110000 / 300", flags, mem_addr);
      end
      next_cycle();
      inst_req = 1'b0;
      #1;
      checks++;
      if (flags !== 6'b101000 || mem_addr !== 32'h400 || mem_wr !== 1'b1
          || mem_wdata !== 32'hdead_beef || mem_wstrb !== 4'hf) begin
         errors++;
         $display("FAIL lock_then_data: flags %b addr %h wr %b wd %h strb %h",
                  flags, mem_addr, mem_wr, mem_wdata, mem_wstrb);
      end
      next_cycle();
      idle_inputs();
      mem_data_ok = 1'b1; mem_rdata = 32'h0000_0033;
      #1;
      checks++;
      if (flags !== 6'b000100 || inst_rdata !== 32'h33) begin
         errors++;
         $display("FAIL lock_resp_inst: flags %b ird %h want 000100 / 33", flags, inst_rdata);
      end
      next_cycle();
      #1;
      checks++;
      if (flags !== 6'b000010) begin
         errors++;
         $display("FAIL lock_resp_data: flags %b want 000010", flags);
      end
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_full();
      inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0000_0500;
      mem_addr_ok = 1'b1;
      #1;
      checks++;
      if (flags !== 6'b110000) begin
         errors++;
         $display("FAIL full_accept0: flags %b want 110000", flags);
      end
      next_cycle();
      #1;
      checks++;
      if (flags !== 6'b110000) begin
         errors++;
         $display("FAIL full_accept1: flags %b want 110000", flags);
      end
      next_cycle();
      #1;
      checks++;
      if (flags !== 6'b000000) begin
         errors++;
         $display("FAIL full_blocked: flags %b want 000000", flags);
      end
      next_cycle();
      mem_data_ok = 1'b1;
      #1;
      checks++;
      if (flags !== 6'b000100) begin
         errors++;
         $display("FAIL full_pop_blocked: flags %b want 000100", flags);
      end
      next_cycle();
      #1;
      checks++;
      if (flags !== 6'b110100) begin
         errors++;
         $display("FAIL full_push_pop: flags %b want 110100", flags);
      end
      next_cycle();
      mem_data_ok = 1'b0;
      #1;
      checks++;
      if (flags !== 6'b110000) begin
         errors++;
         $display("FAIL full_count_kept: flags %b want 110000", flags);
      end
      next_cycle();
      #1;
      checks++;
      if (flags !== 6'b000000) begin
         errors++;
         $display("FAIL full_again: flags %b want 000000", flags);
      end
      next_cycle();
      idle_inputs();
      mem_data_ok = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (flags !== 6'b000100) begin
            errors++;
            $display("FAIL full_drain_%0d: flags %b want 000100", k, flags);
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_proto_err();
      mem_data_ok = 1'b1; mem_rdata = 32'h0000_00aa;
      #1;
      checks++;
      if (flags !== 6'b000000 || inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin
         errors++;
         $display("FAIL perr_no_pulse: flags %b ird %h drd %h want 000000 / 0 / 0",
                  flags, inst_rdata, data_rdata);
      end
      next_cycle();
      mem_data_ok = 1'b0;
      #1;
      checks++;
      if (proto_err !== 1'b1) begin
         errors++;
         $display("FAIL perr_set: got %b want 1", proto_err);
      end
      for (int k = 0; k < 3; k++) next_cycle();
      #1;
      checks++;
      if (proto_err !== 1'b1) begin
         errors++;
         $display("FAIL perr_sticky: got %b want 1", proto_err);
      end
   endtask

   task automatic test_reset_mid();
      resetn = 1'b0;
      #2;
      next_cycle();
      resetn = 1'b1;
      next_cycle();
      inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0000_0600;
      mem_addr_ok = 1'b1;
      #1;
      checks++;
      if (flags !== 6'b110000) begin
         errors++;
         $display("FAIL rmid_accept: flags %b want 110000", flags);
      end
      next_cycle();
      inst_req = 1'b0; mem_addr_ok = 1'b0;
      data_req = 1'b1; data_addr = 32'h0000_0700; data_size = 2'd2;
      next_cycle();
      resetn = 1'b0;
      #1;
      checks++;
      if (flags !== 6'b000000 || mem_addr !== 32'd0) begin
         errors++;
         $display("FAIL rmid_outputs: flags %b addr %h want 000000 / 0", flags, mem_addr);
      end
      next_cycle();
      idle_inputs();
      resetn = 1'b1;
      next_cycle();
      mem_data_ok = 1'b1; mem_rdata = 32'h0000_0077;
      #1;
      checks++;
      if (flags !== 6'b000000) begin
         errors++;
         $display("FAIL rmid_stale_resp: flags %b want 000000", flags);
      end
      next_cycle();
      mem_data_ok = 1'b0;
      #1;
      checks++;
      if (proto_err !== 1'b1) begin
         errors++;
         $display("FAIL rmid_perr: got %b want 1", proto_err);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_idle();
      test_priority();
      test_lock();
      test_full();
      test_proto_err();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
